// File: rtl/digit_serial_adder.sv
// Digit-serial add/subtract unit. Processes DIGIT bits of two WIDTH-bit
// operands per clock, LSB digit first, through one DIGIT-bit ripple slice
// with a registered carry between digits. A start/busy/done handshake frames
// each operation; sum/cout/ovf update only when an operation completes.
module digit_serial_adder #(
    parameter int WIDTH = 16,
    parameter int DIGIT = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    input  logic             sub,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             ovf
);

    localparam int NDIG  = WIDTH / DIGIT;
    localparam int CNT_W = (NDIG > 1) ? $clog2(NDIG) : 1;
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(NDIG - 1);

    typedef enum logic {
        IDLE,
        RUN
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] a_sh_q, a_sh_d;
    logic [WIDTH-1:0] b_sh_q, b_sh_d;
    logic [WIDTH-1:0] res_q, res_d;
    logic             carry_q, carry_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic [WIDTH-1:0] sum_q, sum_d;
    logic             cout_q, cout_d;
    logic             ovf_q, ovf_d;

    // Per-digit slice results shared by the next-state logic.
    logic [DIGIT:0]   slice;
    logic             c_into_msb;
    logic [WIDTH-1:0] dsum_ext;
    logic [WIDTH-1:0] res_next;

    // Ripple slice on the current low digit, plus the assembled result word.
    always_comb begin
        slice = {1'b0, a_sh_q[DIGIT-1:0]}
              + {1'b0, b_sh_q[DIGIT-1:0]}
              + {{DIGIT{1'b0}}, carry_q};
        // Carry into the slice MSB recovered from that bit's sum and operands,
        // so DIGIT=1 needs no special case.
        c_into_msb = slice[DIGIT-1] ^ a_sh_q[DIGIT-1] ^ b_sh_q[DIGIT-1];
        dsum_ext = '0;
        dsum_ext[DIGIT-1:0] = slice[DIGIT-1:0];
        // New digit enters on the MSB side; earlier digits move toward the LSB.
        res_next = (res_q >> DIGIT) | (dsum_ext << (WIDTH - DIGIT));
    end

    // Next-state logic: accept in IDLE, one digit per cycle in RUN.
    always_comb begin
        state_d = state_q;
        a_sh_d  = a_sh_q;
        b_sh_d  = b_sh_q;
        res_d   = res_q;
        carry_d = carry_q;
        cnt_d   = cnt_q;
        busy_d  = busy_q;
        done_d  = 1'b0;
        sum_d   = sum_q;
        cout_d  = cout_q;
        ovf_d   = ovf_q;
        case (state_q)
            IDLE: begin
                if (start) begin
                    a_sh_d  = a;
                    b_sh_d  = sub ? ~b : b;
                    carry_d = sub ? 1'b1 : cin;
                    cnt_d   = '0;
                    busy_d  = 1'b1;
                    state_d = RUN;
                end
            end
            RUN: begin
                a_sh_d  = a_sh_q >> DIGIT;
                b_sh_d  = b_sh_q >> DIGIT;
                carry_d = slice[DIGIT];
                res_d   = res_next;
                cnt_d   = cnt_q + CNT_W'(1);
                if (cnt_q == LAST_CNT) begin
                    cnt_d   = '0;
                    state_d = IDLE;
                    busy_d  = 1'b0;
                    done_d  = 1'b1;
                    sum_d   = res_next;
                    cout_d  = slice[DIGIT];
                    ovf_d   = slice[DIGIT] ^ c_into_msb;
                end
            end
            default: begin
                state_d = IDLE;
                busy_d  = 1'b0;
            end
        endcase
    end

    // State, datapath and registered outputs; reset aborts any operation.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            a_sh_q  <= '0;
            b_sh_q  <= '0;
            res_q   <= '0;
            carry_q <= 1'b0;
            cnt_q   <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            sum_q   <= '0;
            cout_q  <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            a_sh_q  <= a_sh_d;
            b_sh_q  <= b_sh_d;
            res_q   <= res_d;
            carry_q <= carry_d;
            cnt_q   <= cnt_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            sum_q   <= sum_d;
            cout_q  <= cout_d;
            ovf_q   <= ovf_d;
        end
    end

    assign busy = busy_q;
    assign done = done_q;
    assign sum  = sum_q;
    assign cout = cout_q;
    assign ovf  = ovf_q;

endmodule
